// File: rtl/ascii_case_pkg.sv
// Shared constants and types for the ASCII case-conversion stream blocks.
// Holds the letter bounds, the case offset and the two-entry buffer state encoding.
package ascii_case_pkg;

   typedef logic [7:0] ascii_byte_t;

   localparam ascii_byte_t ASCII_UPPER_A  = 8'd65;
   localparam ascii_byte_t ASCII_UPPER_Z  = 8'd90;
   localparam ascii_byte_t ASCII_LOWER_A  = 8'd97;
   localparam ascii_byte_t ASCII_LOWER_Z  = 8'd122;
   localparam ascii_byte_t ASCII_CASE_OFS = 8'd32;

   // Number of entries held by the output buffer (head register plus skid slot).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } buf_state_t;

   function automatic logic is_upper_ascii(input ascii_byte_t b);
      return (b >= ASCII_UPPER_A) && (b <= ASCII_UPPER_Z);
   endfunction

endpackage

// File: rtl/ascii_to_lower_stream_if.sv
// Byte stream with a valid/ready handshake.
// The master drives data and valid; the slave drives ready.
interface ascii_to_lower_stream_if;
   import ascii_case_pkg::*;

   ascii_byte_t data;
   logic        valid;
   logic        ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ascii_lower_char.sv
// Combinational byte map: uppercase ASCII letters become lowercase.
// Every other byte passes through unchanged. is_upper flags the letters that were mapped.
module ascii_lower_char
   import ascii_case_pkg::*;
(
   input  ascii_byte_t in_byte,
   output ascii_byte_t lower_byte,
   output logic        is_upper
);

   assign is_upper   = is_upper_ascii(in_byte);
   assign lower_byte = is_upper ? (in_byte + ASCII_CASE_OFS) : in_byte;

endmodule

// File: rtl/ascii_to_lower_stream.sv
// Streaming uppercase-to-lowercase converter with a two-entry output buffer.
// Also keeps saturating counts of converted bytes and of bytes passed through.
module ascii_to_lower_stream
   import ascii_case_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ascii_to_lower_stream_if.slave  in_if,
   ascii_to_lower_stream_if.master out_if,
   input  logic                    clr_cnt,
   output logic [CNT_W-1:0]        conv_count,
   output logic [CNT_W-1:0]        pass_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   buf_state_t  state, state_nxt;
   ascii_byte_t head, head_nxt;
   ascii_byte_t skid, skid_nxt;
   ascii_byte_t conv_byte;
   logic        conv_upper;
   logic        push, pop;

   ascii_lower_char u_lower (
      .in_byte    (in_if.data),
      .lower_byte (conv_byte),
      .is_upper   (conv_upper)
   );

   // Both handshake outputs decode the state register only, so out_ready never
   // reaches in_ready combinationally.
   assign in_if.ready  = (state != FULL);
   assign out_if.valid = (state != EMPTY);
   assign out_if.data  = head;

   assign push = in_if.valid & in_if.ready;
   assign pop  = out_if.valid & out_if.ready;

   always_comb begin
      // NOTE: every output of this block gets a default first; a path that
      // leaves one unassigned would infer a latch.
      state_nxt = state;
      head_nxt  = head;
      skid_nxt  = skid;
      unique case (state)
         EMPTY: begin
            if (push) begin
               state_nxt = ONE;
               head_nxt  = conv_byte;
            end
         end
         ONE: begin
            if (push && !pop) begin
               state_nxt = FULL;
               skid_nxt  = conv_byte;
            end else if (!push && pop) begin
               state_nxt = EMPTY;
            end else if (push && pop) begin
               head_nxt  = conv_byte;
            end
         end
         FULL: begin
            if (pop) begin
               state_nxt = ONE;
               head_nxt  = skid;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are reset too, because out_data must read
         // zero after reset; there are only two of them, so clearing them is cheap.
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments, so every
         // register samples the values from before the clock edge.
         state <= state_nxt;
         head  <= head_nxt;
         skid  <= skid_nxt;
      end
   end

   // Clear takes priority over the count for a push in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_count <= '0;
         pass_count <= '0;
      end else if (clr_cnt) begin
         conv_count <= '0;
         pass_count <= '0;
      end else if (push) begin
         if (conv_upper) begin
            if (conv_count != CNT_MAX) conv_count <= conv_count + 1'b1;
         end else begin
            if (pass_count != CNT_MAX) pass_count <= pass_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_ascii_to_lower_stream.sv
// Directed bench for ascii_to_lower_stream.
// Expected bytes are queued at push time and compared as the consumer pops them.
module tb_ascii_to_lower_stream;
   import ascii_case_pkg::*;

   logic clk;
   logic rst_n;
   logic clr_cnt;
   logic clr4;
   logic [15:0] conv_count, pass_count;
   logic [3:0]  conv4, pass4;

   ascii_to_lower_stream_if i_if ();
   ascii_to_lower_stream_if o_if ();
   ascii_to_lower_stream_if i4_if ();
   ascii_to_lower_stream_if o4_if ();

   ascii_to_lower_stream #(.CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (i_if),
      .out_if     (o_if),
      .clr_cnt    (clr_cnt),
      .conv_count (conv_count),
      .pass_count (pass_count)
   );

   ascii_to_lower_stream #(.CNT_W(4)) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_if      (i4_if),
      .out_if     (o4_if),
      .clr_cnt    (clr4),
      .conv_count (conv4),
      .pass_count (pass4)
   );

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;
   int last_push_cyc;
   int first_push_cyc;
   bit full_seen;
   logic [7:0] sb[$];
   logic [7:0] obs_log[$];
   int         pop_cyc[$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] exp_lower(input logic [7:0] b);
      return (b >= 8'd65 && b <= 8'd90) ? b + 8'd32 : b;
   endfunction

   // Consumer side: every pop must match the oldest queued byte.
   always @(negedge clk) begin
      if (rst_n && !i_if.ready) full_seen = 1'b1;
      if (rst_n && o_if.valid && o_if.ready) begin
         check("sb_has_entry", (sb.size() != 0), 1);
         if (sb.size() != 0) begin
            check("out_byte", o_if.data, sb.pop_front());
            obs_log.push_back(o_if.data);
            pop_cyc.push_back(cyc);
         end
      end
   end

   task automatic push_byte(input logic [7:0] b);
      bit accepted = 1'b0;
      i_if.data  = b;
      i_if.valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (i_if.ready) begin
            sb.push_back(exp_lower(b));
            last_push_cyc = cyc;
            accepted = 1'b1;
            break;
         end
      end
      check("push_accepted", accepted, 1);
      @(posedge clk);
      #1;
      i_if.valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit drained = 1'b0;
      for (int t = 0; t < 400; t++) begin
         @(negedge clk);
         if (sb.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      check("drain_done", drained, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      clr_cnt     = 1'b0;
      clr4        = 1'b0;
      i_if.data   = 8'h00;
      i_if.valid  = 1'b0;
      o_if.ready  = 1'b0;
      i4_if.data  = 8'h00;
      i4_if.valid = 1'b0;
      o4_if.ready = 1'b1;

      // 1. reset / idle
      #22 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", o_if.valid, 0);
      check("rst_out_data", o_if.data, 0);
      check("rst_in_ready", i_if.ready, 1);
      check("rst_conv_count", conv_count, 0);
      check("rst_pass_count", pass_count, 0);
      @(posedge clk);
      #1;

      // 2. full map sweep at one byte per cycle
      o_if.ready = 1'b1;
      obs_log.delete();
      for (int b = 0; b < 256; b++) push_byte(8'(b));
      wait_drain();
      check("sweep_count", obs_log.size(), 256);
      if (obs_log.size() == 256) begin
         check("map_65", obs_log[65], 97);
         check("map_77", obs_log[77], 109);
         check("map_90", obs_log[90], 122);
         check("map_64", obs_log[64], 64);
         check("map_91", obs_log[91], 91);
         check("map_96", obs_log[96], 96);
         check("map_97", obs_log[97], 97);
         check("map_122", obs_log[122], 122);
         check("map_123", obs_log[123], 123);
         check("map_127", obs_log[127], 127);
         check("map_183", obs_log[183], 183);
         check("map_235", obs_log[235], 235);
      end
      check("sweep_conv_count", conv_count, 26);
      check("sweep_pass_count", pass_count, 230);

      // 3. backpressure fills both entries
      o_if.ready = 1'b0;
      push_byte(8'd72);
      push_byte(8'd40);
      @(negedge clk);
      check("bp_in_ready", i_if.ready, 0);
      check("bp_out_valid", o_if.valid, 1);
      check("bp_out_data", o_if.data, 104);
      repeat (2) @(negedge clk);
      check("bp_hold_data", o_if.data, 104);
      @(posedge clk);
      #1;
      o_if.ready = 1'b1;
      wait_drain();
      @(negedge clk);
      check("bp_in_ready_back", i_if.ready, 1);
      check("bp_out_valid_off", o_if.valid, 0);
      @(posedge clk);
      #1;

      // 4. simultaneous push/pop keeps the buffer at one entry
      full_seen = 1'b0;
      pop_cyc.delete();
      push_byte(8'd65);
      first_push_cyc = last_push_cyc;
      push_byte(8'd66);
      push_byte(8'd67);
      wait_drain();
      check("stream_pops", pop_cyc.size(), 3);
      if (pop_cyc.size() == 3) begin
         check("stream_latency", pop_cyc[0] - first_push_cyc, 1);
         check("stream_gap_1", pop_cyc[1] - pop_cyc[0], 1);
         check("stream_gap_2", pop_cyc[2] - pop_cyc[1], 1);
      end
      check("stream_never_full", full_seen, 0);

      // 5. saturating counter on the narrow instance, then clear during a push
      i4_if.data  = 8'd65;
      i4_if.valid = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      i4_if.valid = 1'b0;
      @(negedge clk);
      check("sat_conv4", conv4, 15);
      check("sat_pass4", pass4, 0);
      @(posedge clk);
      #1;
      i4_if.valid = 1'b1;
      clr4        = 1'b1;
      @(posedge clk);
      #1;
      i4_if.valid = 1'b0;
      clr4        = 1'b0;
      @(negedge clk);
      check("clr_conv4", conv4, 0);
      check("clr_pass4", pass4, 0);
      check("clr_out_data4", o4_if.data, 97);
      @(posedge clk);
      #1;

      // 6. asynchronous reset while the buffer is full
      o_if.ready = 1'b0;
      push_byte(8'd90);
      push_byte(8'd123);
      @(negedge clk);
      check("pre_rst_full", i_if.ready, 0);
      check("pre_rst_head", o_if.data, 122);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("async_out_valid", o_if.valid, 0);
      check("async_in_ready", i_if.ready, 1);
      sb.delete();
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      o_if.ready = 1'b1;
      repeat (5) @(negedge clk);
      check("post_rst_out_valid", o_if.valid, 0);
      check("post_rst_out_data", o_if.data, 0);
      check("post_rst_conv", conv_count, 0);
      check("post_rst_pass", pass_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
